// File: rtl/tr_drain_engine.sv
// Tie-record drain engine: registers one TR vector and emits the address of each
// set bit per accepted beat, LSB- or MSB-first, with count/index/last/empty info.
module tr_drain_engine #(
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = $clog2(ELEMENT_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ELEMENT_NUM-1:0]      in_vec,
  input  logic                        in_msb_first,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LOG2_ELEMENT_NUM-1:0] out_addr,
  output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
  output logic                        out_last,
  output logic [LOG2_ELEMENT_NUM:0]   out_dup_cnt,
  output logic                        empty_pulse,
  output logic                        busy
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [ELEMENT_NUM-1:0]      tr_q;
  logic                        dir_q;
  logic [LOG2_ELEMENT_NUM-1:0] idx_q;
  logic [LOG2_ELEMENT_NUM:0]   cnt_q;
  logic                        empty_q;

  logic [LOG2_ELEMENT_NUM:0]   in_cnt;
  logic [LOG2_ELEMENT_NUM-1:0] sel;
  logic                        load, accept, in_zero, one_hot;

  // Extra count bit so a full vector reports ELEMENT_NUM rather than wrapping.
  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < ELEMENT_NUM; i++)
      in_cnt = in_cnt + (LOG2_ELEMENT_NUM+1)'(in_vec[i]);
  end

  assign in_zero = (in_vec == '0);

  // Priority pick: the last match in scan order wins, so scan away from the winner.
  always_comb begin
    sel = '0;
    if (dir_q) begin
      for (int i = 0; i < ELEMENT_NUM; i++)
        if (tr_q[i]) sel = LOG2_ELEMENT_NUM'(i);
    end else begin
      for (int i = ELEMENT_NUM-1; i >= 0; i--)
        if (tr_q[i]) sel = LOG2_ELEMENT_NUM'(i);
    end
  end

  assign one_hot = (tr_q != '0) && ((tr_q & (tr_q - 1'b1)) == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          if (!in_zero) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          accept = 1'b1;
          if (one_hot) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_q    <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      empty_q <= load && in_zero;
      if (load) begin
        tr_q  <= in_vec;
        dir_q <= in_msb_first;
        idx_q <= '0;
        cnt_q <= in_cnt;
      end else if (accept) begin
        tr_q[sel] <= 1'b0;
        idx_q     <= idx_q + 1'b1;
      end
    end
  end

  assign out_addr    = sel;
  assign out_idx     = idx_q;
  assign out_last    = one_hot;
  assign out_dup_cnt = cnt_q;
  assign empty_pulse = empty_q;

endmodule

// File: tb/tb_tr_drain_engine.sv
// Self-checking bench for tr_drain_engine: directed table, reset/corner
// sequences, a 5-wide instance and random vectors against a queue-based model.
module tb_tr_drain_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_msb_first;
  logic [15:0] in_vec;
  logic        out_valid, out_ready, out_last, empty_pulse, busy;
  logic [3:0]  out_addr, out_idx;
  logic [4:0]  out_dup_cnt;

  logic        s_in_valid, s_in_ready, s_in_msb_first;
  logic [4:0]  s_in_vec;
  logic        s_out_valid, s_out_ready, s_out_last, s_empty_pulse, s_busy;
  logic [2:0]  s_out_addr, s_out_idx;
  logic [3:0]  s_out_dup_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tr_drain_engine #(.ELEMENT_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_msb_first(in_msb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_idx(out_idx),
    .out_last(out_last), .out_dup_cnt(out_dup_cnt), .empty_pulse(empty_pulse), .busy(busy)
  );

  tr_drain_engine #(.ELEMENT_NUM(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_vec(s_in_vec), .in_msb_first(s_in_msb_first),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_addr(s_out_addr), .out_idx(s_out_idx),
    .out_last(s_out_last), .out_dup_cnt(s_out_dup_cnt), .empty_pulse(s_empty_pulse), .busy(s_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},    in_ready, 1);
    chk({tag, " out_valid"},   out_valid, 0);
    chk({tag, " out_addr"},    out_addr, 0);
    chk({tag, " out_idx"},     out_idx, 0);
    chk({tag, " out_last"},    out_last, 0);
    chk({tag, " out_dup_cnt"}, out_dup_cnt, 0);
    chk({tag, " empty_pulse"}, empty_pulse, 0);
    chk({tag, " busy"},        busy, 0);
  endtask

  // mode 0: out_ready always 1; 1: toggles 1,0,1,...; 2: random
  task automatic drain(input logic [15:0] v, input bit msb, input int mode,
                       output int first_a, output int last_a, output int beats);
    int exp_q[$];
    int k, guard, prev_addr, prev_idx;
    bit rdy, prev_stall;
    for (int j = 0; j < 16; j++) begin
      int b;
      b = msb ? 15 - j : j;
      if (v[b]) exp_q.push_back(b);
    end
    first_a = 0; last_a = 0; beats = 0;
    chk("load in_ready", in_ready, 1);
    in_valid = 1'b1; in_vec = v; in_msb_first = msb;
    step();
    in_valid = 1'b0; in_vec = 16'hDEAD; in_msb_first = ~msb;
    if (exp_q.size() == 0) begin
      chk("empty pulse", empty_pulse, 1);
      chk("empty out_valid", out_valid, 0);
      chk("empty in_ready", in_ready, 1);
      step();
      chk("empty pulse width", empty_pulse, 0);
      chk("empty still idle", in_ready, 1);
      return;
    end
    k = 0; guard = 0; prev_stall = 1'b0; prev_addr = 0; prev_idx = 0;
    while (k < exp_q.size() && guard < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 16'($urandom);
      chk("beat out_valid", out_valid, 1);
      chk("beat out_addr", out_addr, exp_q[k]);
      chk("beat out_idx", out_idx, k);
      chk("beat out_dup_cnt", out_dup_cnt, exp_q.size());
      chk("beat out_last", out_last, (k == exp_q.size() - 1) ? 1 : 0);
      chk("beat in_ready", in_ready, 0);
      chk("beat busy", busy, 1);
      if (prev_stall) begin
        chk("stall addr stable", out_addr, prev_addr);
        chk("stall idx stable", out_idx, prev_idx);
      end
      if (rdy) begin
        if (k == 0) first_a = out_addr;
        last_a = out_addr;
      end
      prev_stall = !rdy; prev_addr = out_addr; prev_idx = out_idx;
      step();
      if (rdy) k++;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    beats = k;
    chk("drain cycle budget", (guard < 200) ? 1 : 0, 1);
    chk("post drain in_ready", in_ready, 1);
    chk("post drain out_valid", out_valid, 0);
    chk("post drain busy", busy, 0);
  endtask

  typedef struct {
    logic [15:0] vec;
    bit          msb;
    int          mode;
    int          exp_first;
    int          exp_last;
    int          exp_beats;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int fa, la, nb;

    tbl[0] = '{16'h0000, 1'b0, 0, 0,  0,  0};
    tbl[1] = '{16'h00A4, 1'b0, 0, 2,  7,  3};
    tbl[2] = '{16'h00A4, 1'b1, 0, 7,  2,  3};
    tbl[3] = '{16'hFFFF, 1'b0, 1, 0,  15, 16};
    tbl[4] = '{16'h8000, 1'b1, 2, 15, 15, 1};
    tbl[5] = '{16'h8001, 1'b1, 1, 15, 0,  2};

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_msb_first = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_vec = '0; s_in_msb_first = 1'b0; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    foreach (tbl[i]) begin
      drain(tbl[i].vec, tbl[i].msb, tbl[i].mode, fa, la, nb);
      chk($sformatf("tbl%0d beats", i), nb, tbl[i].exp_beats);
      if (tbl[i].exp_beats > 0) begin
        chk($sformatf("tbl%0d first", i), fa, tbl[i].exp_first);
        chk($sformatf("tbl%0d last", i), la, tbl[i].exp_last);
      end
      step();
    end

    // Reset in the middle of a drain abandons it.
    in_valid = 1'b1; in_vec = 16'h8001; in_msb_first = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mid first addr", out_addr, 0);
    chk("mid first valid", out_valid, 1);
    step();
    chk("mid second addr", out_addr, 15);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk_reset_vals("mid reset");
    step();
    chk("after reset no beat", out_valid, 0);
    out_ready = 1'b0;
    drain(16'h0010, 1'b0, 0, fa, la, nb);
    chk("reload beats", nb, 1);
    chk("reload addr", fa, 4);

    // 5-wide instance, MSB-first.
    s_in_valid = 1'b1; s_in_vec = 5'b10001; s_in_msb_first = 1'b1; s_out_ready = 1'b1;
    step();
    s_in_valid = 1'b0;
    chk("w5 beat0 valid", s_out_valid, 1);
    chk("w5 beat0 addr", s_out_addr, 4);
    chk("w5 beat0 idx", s_out_idx, 0);
    chk("w5 beat0 dup", s_out_dup_cnt, 2);
    chk("w5 beat0 last", s_out_last, 0);
    step();
    chk("w5 beat1 addr", s_out_addr, 0);
    chk("w5 beat1 idx", s_out_idx, 1);
    chk("w5 beat1 last", s_out_last, 1);
    step();
    chk("w5 idle ready", s_in_ready, 1);
    chk("w5 idle valid", s_out_valid, 0);
    s_in_valid = 1'b1; s_in_vec = 5'b11111; s_in_msb_first = 1'b0;
    step();
    s_in_valid = 1'b0;
    chk("w5 full dup", s_out_dup_cnt, 5);
    repeat (5) step();
    chk("w5 full done", s_in_ready, 1);
    s_out_ready = 1'b0;

    // Random vectors; sparse and dense masks mixed.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (r % 4 == 1) v = v & 16'($urandom) & 16'($urandom);
      if (r % 10 == 3) v = 16'h0000;
      drain(v, 1'($urandom_range(0, 1)), 2, fa, la, nb);
      chk($sformatf("rand%0d beats", r), nb, $countones(v));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
